// File: rtl/banked_memory_manager_if.sv
// Data-side bus between the core datapath and the banked memory manager.
// The master drives op/addr/write_data; the slave returns ready, read data and strobes.
interface banked_memory_manager_if #(
  parameter int WORD_SIZE = 8
);
  logic [1:0]           op;
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] write_data;
  logic                 ready;
  logic [WORD_SIZE-1:0] read_data;
  logic                 rd_valid;
  logic                 addr_err;

  modport master (
    output op, addr, write_data,
    input  ready, read_data, rd_valid, addr_err
  );

  modport slave (
    input  op, addr, write_data,
    output ready, read_data, rd_valid, addr_err
  );
endinterface

// File: rtl/banked_memory_manager.sv
// Data/program memory manager for the z8 core: common region plus a bank-switched
// window, registered reads, a sequenced clear engine and a writable program store.
//
// state    | meaning
// ST_CLEAR | zeroing data RAM one word per cycle, ops ignored, ready=0
// ST_RUN   | ready=1, READ/WRITE/CLEAR ops accepted every cycle
module banked_memory_manager #(
  parameter int WORD_SIZE   = 8,
  parameter int INSTR_SIZE  = 16,
  parameter int PROG_DEPTH  = 256,
  parameter int COMMON_SIZE = 64,
  parameter int BANK_SIZE   = 32,
  parameter int NUM_BANKS   = 4,
  parameter int CTRL_ADDR   = COMMON_SIZE - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  banked_memory_manager_if.slave        bus,
  input  logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [INSTR_SIZE-1:0]         current_instruction,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_SIZE-1:0]         prog_wdata,
  output logic [$clog2(NUM_BANKS)-1:0]  bank_sel
);

  localparam int PHYS   = COMMON_SIZE + NUM_BANKS * BANK_SIZE;
  localparam int PHYS_W = $clog2(PHYS);
  localparam int BS_W   = $clog2(NUM_BANKS);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [PHYS_W-1:0]     clear_ptr_q, clear_ptr_d;
  logic [WORD_SIZE-1:0]  read_data_q, read_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic [BS_W-1:0]       bank_sel_q, bank_sel_d;
  logic [INSTR_SIZE-1:0] current_instruction_q, current_instruction_d;

  logic [WORD_SIZE-1:0]  data_mem [PHYS];
  logic [INSTR_SIZE-1:0] prog_mem [PROG_DEPTH];

  logic [31:0]           addr_ext;
  logic                  in_common, in_window, in_range;
  logic [PHYS_W-1:0]     phys_idx;
  logic                  mem_we;
  logic [PHYS_W-1:0]     mem_waddr;
  logic [WORD_SIZE-1:0]  mem_wdata;

  // Window words sit after the common region: phys = bank*BANK_SIZE + logical addr.
  always_comb begin
    addr_ext  = 32'(bus.addr);
    in_common = addr_ext < 32'(COMMON_SIZE);
    in_window = !in_common && (addr_ext < 32'(COMMON_SIZE + BANK_SIZE));
    in_range  = in_common || in_window;
    if (in_window) phys_idx = PHYS_W'(32'(bank_sel_q) * 32'(BANK_SIZE) + addr_ext);
    else           phys_idx = PHYS_W'(addr_ext);
  end

  always_comb begin
    state_d               = state_q;
    clear_ptr_d           = clear_ptr_q;
    read_data_d           = read_data_q;
    rd_valid_d            = 1'b0;
    addr_err_d            = 1'b0;
    bank_sel_d            = bank_sel_q;
    current_instruction_d = prog_mem[pc];
    mem_we                = 1'b0;
    mem_waddr             = clear_ptr_q;
    mem_wdata             = '0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == PHYS_W'(PHYS - 1)) begin
          state_d     = ST_RUN;
          clear_ptr_d = '0;
        end
      end
      ST_RUN: begin
        unique case (bus.op)
          OP_READ: begin
            rd_valid_d  = 1'b1;
            addr_err_d  = !in_range;
            read_data_d = in_range ? data_mem[phys_idx] : '0;
          end
          OP_WRITE: begin
            addr_err_d = !in_range;
            if (in_range) begin
              mem_we    = 1'b1;
              mem_waddr = phys_idx;
              mem_wdata = bus.write_data;
            end
            if (addr_ext == 32'(CTRL_ADDR)) bank_sel_d = bus.write_data[BS_W-1:0];
          end
          OP_CLEAR: begin
            // The control word is about to be zeroed, so the bank follows it.
            state_d     = ST_CLEAR;
            clear_ptr_d = '0;
            bank_sel_d  = '0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q               <= ST_CLEAR;
      clear_ptr_q           <= '0;
      read_data_q           <= '0;
      rd_valid_q            <= 1'b0;
      addr_err_q            <= 1'b0;
      bank_sel_q            <= '0;
      current_instruction_q <= '0;
    end else begin
      state_q               <= state_d;
      clear_ptr_q           <= clear_ptr_d;
      read_data_q           <= read_data_d;
      rd_valid_q            <= rd_valid_d;
      addr_err_q            <= addr_err_d;
      bank_sel_q            <= bank_sel_d;
      current_instruction_q <= current_instruction_d;
    end
  end

  // RAM arrays carry no reset; the clear engine owns data initialisation.
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_waddr] <= mem_wdata;
    if (prog_we) prog_mem[prog_addr] <= prog_wdata;
  end

  assign bus.ready           = (state_q == ST_RUN);
  assign bus.read_data       = read_data_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.addr_err        = addr_err_q;
  assign bank_sel            = bank_sel_q;
  assign current_instruction = current_instruction_q;

endmodule

// File: doc/banked_memory_manager.md
Name: banked_memory_manager

Overview:
Parametrised data/program memory manager for the z8 core, adding N-way data-bank switching, registered reads with a valid strobe, and a sequenced clear engine. Data space is one common region plus a banked window whose physical bank is chosen by a control word held in common memory. Program memory is writable through a dedicated load port, and instruction fetch is registered. Sits between the core datapath/fetch unit and on-chip RAM.

Parameters:
WORD_SIZE, 8, data word and data-address width
INSTR_SIZE, 16, instruction width
PROG_DEPTH, 256, program memory words
COMMON_SIZE, 64, unbanked words at logical addresses 0..COMMON_SIZE-1
BANK_SIZE, 32, words per bank, at logical addresses COMMON_SIZE..COMMON_SIZE+BANK_SIZE-1
NUM_BANKS, 4, bank count (power of two, >=2)
CTRL_ADDR, COMMON_SIZE-1, common-region address of the control word

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
op  in  2  2'b00 NOP, 2'b01 READ, 2'b10 WRITE, 2'b11 CLEAR
addr  in  WORD_SIZE  logical data address
write_data  in  WORD_SIZE  write data
ready  out  1  1 = op accepted this cycle; 0 during clear
read_data  out  WORD_SIZE  registered read data
rd_valid  out  1  one-cycle strobe, read_data valid
addr_err  out  1  one-cycle strobe, accepted READ/WRITE to out-of-range address
pc  in  $clog2(PROG_DEPTH)  fetch address
current_instruction  out  INSTR_SIZE  registered prog_mem[pc]
prog_we  in  1  program memory write enable
prog_addr  in  $clog2(PROG_DEPTH)  program write address
prog_wdata  in  INSTR_SIZE  program write data
bank_sel  out  $clog2(NUM_BANKS)  active bank, = control word low bits

Behaviour:
- Physical data RAM: PHYS = COMMON_SIZE + NUM_BANKS*BANK_SIZE words. Common addr a -> phys a. Window addr a -> phys COMMON_SIZE + bank_sel*BANK_SIZE + (a-COMMON_SIZE). Addr >= COMMON_SIZE+BANK_SIZE is out of range.
- States: CLEAR, RUN. Reset asserted: state=CLEAR, clear_ptr=0, ready=0, read_data=0, rd_valid=0, addr_err=0, bank_sel=0, current_instruction=0.
- CLEAR: each cycle phys[clear_ptr]<=0 and clear_ptr++. When clear_ptr==PHYS-1 is written, go to RUN next cycle. Clear takes exactly PHYS cycles and bank_sel stays 0. All ops are ignored, with no strobes.
- RUN: ready=1. An op presented in RUN is accepted in that cycle.
- READ accepted in cycle N: read_data = word and rd_valid=1 in cycle N+1 only. An out-of-range READ gives read_data=0, rd_valid=1 and addr_err=1 in N+1.
- WRITE: in-range updates RAM at the edge. Out-of-range is dropped and addr_err=1 next cycle.
- WRITE to CTRL_ADDR updates bank_sel from write_data[$clog2(NUM_BANKS)-1:0] at the same edge. Upper bits are stored but ignored.
- A READ in the cycle after a WRITE to the same address returns the new data. A window access in the cycle after a CTRL write uses the new bank.
- CLEAR op in RUN: enter CLEAR next cycle, clear_ptr=0, ready=0.
- read_data holds its last value when rd_valid=0.
- Fetch: current_instruction <= prog_mem[pc] every edge, in both states, giving 1-cycle latency. If prog_we hits the same address in the same cycle, fetch returns the old word.
- Program memory is not cleared by reset or CLEAR, and prog_we is honoured in both states.
- Reset asserted mid-clear or mid-read: outputs drop to reset values immediately and the clear restarts from 0.

Test Plan:
- Reset release with defaults -> ready=0 for 192 cycles, then 1. Every READ addr 0..95 returns 0 with rd_valid one cycle after issue.
- WRITE 0x5A to addr 10, then READ 10 next cycle -> read_data=0x5A, rd_valid=1 exactly one cycle.
- Bank switching: WRITE 0x02 to CTRL 63, then WRITE 0xAA to addr 64. WRITE 0x00 to CTRL, then READ 64 -> 0x00. WRITE 0x02 to CTRL, then READ 64 -> 0xAA. bank_sel tracks 2,0,2.
- READ 200 -> read_data=0, rd_valid=1, addr_err=1. WRITE 200 -> addr_err=1, no RAM change.
- prog_we writes 0x1234 to addr 5, with pc=5 in the same cycle -> old value, then 0x1234 next cycle. CLEAR op -> ready low 192 cycles, data zeroed, prog_mem[5] still 0x1234.
- Assert reset at clear_ptr=50 -> immediate reset outputs. Release -> full 192-cycle clear from 0.
